occ_link_pattern_gen_chk: RTL and testbench

//  Parametrised multi-lane 8b/10b link test-pattern generator and checker for OCC transceiver bring-up.

---
 rtl/occ_link_pattern_pkg.sv | 32 +++
 rtl/occ_link_pattern_gen_chk_if.sv | 32 +++
 rtl/occ_link_pattern_chk_lane.sv | 123 ++++++++++++
 rtl/occ_link_pattern_gen_chk.sv | 78 +++++++
 tb/tb_occ_link_pattern_gen_chk.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/occ_link_pattern_pkg.sv
// Shared constants, checker state encoding and comma-word builders for the
// OCC 8b/10b link pattern generator/checker.
package occ_link_pattern_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] FILLER    = 8'h95;
  localparam int         MAX_BYTES = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // K28.5 sits in the most significant byte of the lane word.
  function automatic logic [8*MAX_BYTES-1:0] comma_word(input int bytes);
    logic [8*MAX_BYTES-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < bytes) w[8*i +: 8] = (i == bytes - 1) ? K28_5 : FILLER;
    end
    return w;
  endfunction

  function automatic logic [MAX_BYTES-1:0] comma_kmask(input int bytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (i == bytes - 1);
    return m;
  endfunction

endpackage

// File: rtl/occ_link_pattern_gen_chk_if.sv
// Bundle of the GT-side and diagnostics-side signals of the pattern generator/checker.
interface occ_link_pattern_gen_chk_if #(
  parameter int g_LANES     = 1,
  parameter int g_BYTES     = 2,
  parameter int g_CNT_WIDTH = 32
);
  localparam int W = 8 * g_BYTES;

  logic                           gen_en_i;
  logic [g_LANES-1:0]             inj_err_i;
  logic [g_LANES*W-1:0]           txdata_o;
  logic [g_LANES*g_BYTES-1:0]     txcharisk_o;
  logic [g_LANES*W-1:0]           rxdata_i;
  logic [g_LANES*g_BYTES-1:0]     rxcharisk_i;
  logic [g_LANES*g_BYTES-1:0]     rxdisperr_i;
  logic [g_LANES*g_BYTES-1:0]     rxnotintable_i;
  logic                           cnt_clr_i;
  logic [g_LANES-1:0]             locked_o;
  logic [g_LANES*g_CNT_WIDTH-1:0] err_cnt_o;
  logic [g_LANES*g_CNT_WIDTH-1:0] word_cnt_o;

  modport master (
    input  gen_en_i, inj_err_i, rxdata_i, rxcharisk_i, rxdisperr_i, rxnotintable_i, cnt_clr_i,
    output txdata_o, txcharisk_o, locked_o, err_cnt_o, word_cnt_o
  );

  modport slave (
    output gen_en_i, inj_err_i, rxdata_i, rxcharisk_i, rxdisperr_i, rxnotintable_i, cnt_clr_i,
    input  txdata_o, txcharisk_o, locked_o, err_cnt_o, word_cnt_o
  );

endinterface

// File: rtl/occ_link_pattern_chk_lane.sv
// Per-lane receive checker: comma hunt, counter sync, lock tracking and
// saturating error/word counters.
module occ_link_pattern_chk_lane
  import occ_link_pattern_pkg::*;
#(
  parameter int g_BYTES       = 2,
  parameter int g_COMMA_LOG2  = 5,
  parameter int g_LOSS_THRESH = 4,
  parameter int g_CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [8*g_BYTES-1:0]   rxdata_i,
  input  logic [g_BYTES-1:0]     rxcharisk_i,
  input  logic [g_BYTES-1:0]     rxdisperr_i,
  input  logic [g_BYTES-1:0]     rxnotintable_i,
  input  logic                   cnt_clr_i,
  output logic                   locked_o,
  output logic [g_CNT_WIDTH-1:0] err_cnt_o,
  output logic [g_CNT_WIDTH-1:0] word_cnt_o
);
  localparam int                   W          = 8 * g_BYTES;
  localparam int                   L          = g_COMMA_LOG2;
  localparam logic [8*MAX_BYTES-1:0] COMMA_FULL = comma_word(g_BYTES);
  localparam logic [MAX_BYTES-1:0] KMASK_FULL = comma_kmask(g_BYTES);
  localparam logic [W-1:0]         COMMA      = COMMA_FULL[W-1:0];
  localparam logic [g_BYTES-1:0]   KMASK      = KMASK_FULL[g_BYTES-1:0];

  function automatic logic [g_CNT_WIDTH-1:0] sat_inc(input logic [g_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + g_CNT_WIDTH'(1);
  endfunction

  // Stage 1: register the GT receive word and its flags
  logic [W-1:0]       rxdata_q;
  logic [g_BYTES-1:0] rxk_q;
  logic               rxbad_q;

  // Stage 2: checker state and counters
  chk_state_e             state_q, state_d;
  logic [W-1:0]           exp_q, exp_d;
  logic [3:0]             bad_run_q, bad_run_d;
  logic [g_CNT_WIDTH-1:0] err_q, err_d;
  logic [g_CNT_WIDTH-1:0] word_q, word_d;
  logic                   locked_q, locked_d;
  logic                   is_comma;
  logic                   good;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q + W'(1);
    bad_run_d = bad_run_q;
    err_d     = err_q;
    word_d    = word_q;
    is_comma  = (rxdata_q == COMMA) && (rxk_q == KMASK);
    good      = 1'b0;
    case (state_q)
      ST_HUNT: begin
        bad_run_d = '0;
        if (is_comma && !rxbad_q) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if ((rxk_q == '0) && (rxdata_q[L-1:0] == L'(1)) && !rxbad_q) begin
          exp_d   = rxdata_q + W'(1);
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        word_d = sat_inc(word_q);
        if (exp_q[L-1:0] == '0) good = is_comma;
        else                    good = (rxdata_q == exp_q) && (rxk_q == '0);
        if (good && !rxbad_q) begin
          bad_run_d = '0;
        end else begin
          err_d = sat_inc(err_q);
          if (bad_run_q >= 4'(g_LOSS_THRESH - 1)) begin
            bad_run_d = '0;
            state_d   = ST_HUNT;
          end else begin
            bad_run_d = bad_run_q + 4'd1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
    // Clear wins over an increment landing on the same edge.
    if (cnt_clr_i) begin
      err_d  = '0;
      word_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxdata_q  <= '0;
      rxk_q     <= '0;
      rxbad_q   <= 1'b0;
      state_q   <= ST_HUNT;
      exp_q     <= '0;
      bad_run_q <= '0;
      err_q     <= '0;
      word_q    <= '0;
      locked_q  <= 1'b0;
    end else begin
      rxdata_q  <= rxdata_i;
      rxk_q     <= rxcharisk_i;
      rxbad_q   <= (|rxdisperr_i) | (|rxnotintable_i);
      state_q   <= state_d;
      exp_q     <= exp_d;
      bad_run_q <= bad_run_d;
      err_q     <= err_d;
      word_q    <= word_d;
      locked_q  <= locked_d;
    end
  end

  assign locked_o   = locked_q;
  assign err_cnt_o  = err_q;
  assign word_cnt_o = word_q;

endmodule

// File: rtl/occ_link_pattern_gen_chk.sv
// Multi-lane 8b/10b link test-pattern generator (periodic comma + counter)
// with one independent receive checker per lane.
module occ_link_pattern_gen_chk
  import occ_link_pattern_pkg::*;
#(
  parameter int g_LANES       = 1,
  parameter int g_BYTES       = 2,
  parameter int g_COMMA_LOG2  = 5,
  parameter int g_LOSS_THRESH = 4,
  parameter int g_CNT_WIDTH   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  occ_link_pattern_gen_chk_if.master  bus
);
  localparam int                     W          = 8 * g_BYTES;
  localparam int                     B          = g_BYTES;
  localparam logic [8*MAX_BYTES-1:0] COMMA_FULL = comma_word(g_BYTES);
  localparam logic [MAX_BYTES-1:0]   KMASK_FULL = comma_kmask(g_BYTES);
  localparam logic [W-1:0]           COMMA      = COMMA_FULL[W-1:0];
  localparam logic [B-1:0]           KMASK      = KMASK_FULL[B-1:0];

  for (genvar n = 0; n < g_LANES; n++) begin : g_lane
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] txdata_q, txdata_d;
    logic [B-1:0] txk_q, txk_d;
    logic         inj_pend_q, inj_pend_d;

    // A pending injection waits out comma slots and lands on the next data word.
    always_comb begin
      cnt_d      = cnt_q + W'(1);
      inj_pend_d = inj_pend_q | bus.inj_err_i[n];
      txdata_d   = COMMA;
      txk_d      = KMASK;
      if (bus.gen_en_i && (cnt_q[g_COMMA_LOG2-1:0] != '0)) begin
        txdata_d   = cnt_q ^ W'(inj_pend_d);
        txk_d      = '0;
        inj_pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q      <= '0;
        txdata_q   <= COMMA;
        txk_q      <= KMASK;
        inj_pend_q <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        txdata_q   <= txdata_d;
        txk_q      <= txk_d;
        inj_pend_q <= inj_pend_d;
      end
    end

    assign bus.txdata_o[n*W +: W]    = txdata_q;
    assign bus.txcharisk_o[n*B +: B] = txk_q;

    occ_link_pattern_chk_lane #(
      .g_BYTES       (g_BYTES),
      .g_COMMA_LOG2  (g_COMMA_LOG2),
      .g_LOSS_THRESH (g_LOSS_THRESH),
      .g_CNT_WIDTH   (g_CNT_WIDTH)
    ) u_chk (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rxdata_i       (bus.rxdata_i[n*W +: W]),
      .rxcharisk_i    (bus.rxcharisk_i[n*B +: B]),
      .rxdisperr_i    (bus.rxdisperr_i[n*B +: B]),
      .rxnotintable_i (bus.rxnotintable_i[n*B +: B]),
      .cnt_clr_i      (bus.cnt_clr_i),
      .locked_o       (bus.locked_o[n]),
      .err_cnt_o      (bus.err_cnt_o[n*g_CNT_WIDTH +: g_CNT_WIDTH]),
      .word_cnt_o     (bus.word_cnt_o[n*g_CNT_WIDTH +: g_CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_occ_link_pattern_gen_chk.sv
// Loopback bench: two DUT configurations, expectations queued by the stimulus
// and compared by an independent monitor in the middle of each low clock phase.
module tb_occ_link_pattern_gen_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] disperr_a;

  occ_link_pattern_gen_chk_if #(.g_LANES(2), .g_BYTES(2), .g_CNT_WIDTH(32)) if_a ();
  occ_link_pattern_gen_chk_if #(.g_LANES(1), .g_BYTES(4), .g_CNT_WIDTH(4))  if_b ();

  assign if_a.rxdata_i       = if_a.txdata_o;
  assign if_a.rxcharisk_i    = if_a.txcharisk_o;
  assign if_a.rxdisperr_i    = disperr_a;
  assign if_a.rxnotintable_i = '0;
  assign if_b.rxdata_i       = if_b.txdata_o;
  assign if_b.rxcharisk_i    = if_b.txcharisk_o;
  assign if_b.rxdisperr_i    = '0;
  assign if_b.rxnotintable_i = '0;

  occ_link_pattern_gen_chk #(
    .g_LANES(2), .g_BYTES(2), .g_COMMA_LOG2(5), .g_LOSS_THRESH(4), .g_CNT_WIDTH(32)
  ) u_dut_a (.clk_i(clk), .rst_i(rst_a), .bus(if_a));

  occ_link_pattern_gen_chk #(
    .g_LANES(1), .g_BYTES(4), .g_COMMA_LOG2(3), .g_LOSS_THRESH(4), .g_CNT_WIDTH(4)
  ) u_dut_b (.clk_i(clk), .rst_i(rst_b), .bus(if_b));

  // Selectors: 0 lock A, 1 err A, 2 words A, 3 lock B, 4 err B, 5 words B,
  // 6 txdata B, 7 txcharisk B, 8 txdata A, 9 txcharisk A
  typedef struct {
    string       name;
    int          sel;
    int          lane;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] actual(input int sel, input int lane);
    case (sel)
      0:       return 64'(if_a.locked_o[lane]);
      1:       return 64'(if_a.err_cnt_o[lane*32 +: 32]);
      2:       return 64'(if_a.word_cnt_o[lane*32 +: 32]);
      3:       return 64'(if_b.locked_o[0]);
      4:       return 64'(if_b.err_cnt_o);
      5:       return 64'(if_b.word_cnt_o);
      6:       return 64'(if_b.txdata_o);
      7:       return 64'(if_b.txcharisk_o);
      8:       return 64'(if_a.txdata_o[lane*16 +: 16]);
      9:       return 64'(if_a.txcharisk_o[lane*2 +: 2]);
      default: return '1;
    endcase
  endfunction

  task automatic expect_val(input string nm, input int sel, input int lane, input logic [63:0] v);
    exp_t e;
    e.name = nm; e.sel = sel; e.lane = lane; e.exp = v;
    sb_q.push_back(e);
  endtask

  // Monitor: drains queued expectations against the settled DUT outputs.
  always begin
    @(negedge clk);
    #2;
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [63:0] a;
      e = sb_q.pop_front();
      a = actual(e.sel, e.lane);
      n_cmp++;
      if (a !== e.exp) begin
        n_bad++;
        $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h", e.name, e.lane, a, e.exp);
      end
    end
  end

  task automatic wait_lock(input string nm, input int sel, input int lane, input int budget);
    int k = 0;
    while (actual(sel, lane) != 64'd1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    expect_val(nm, sel, lane, 64'd1);
  endtask

  // Park at a negedge where the next generated word on lane 0 of A is data.
  task automatic wait_safe_a();
    int k = 0;
    while (!(if_a.txcharisk_o[1:0] == 2'b00 && if_a.txdata_o[4:0] >= 5'd1 &&
             if_a.txdata_o[4:0] <= 5'd29) && k < 64) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; disperr_a = '0;
    if_a.gen_en_i = 1'b1; if_a.inj_err_i = '0; if_a.cnt_clr_i = 1'b0;
    if_b.gen_en_i = 1'b1; if_b.inj_err_i = '0; if_b.cnt_clr_i = 1'b0;
    repeat (3) @(negedge clk);

    expect_val("rst_locked", 0, 0, 0);
    expect_val("rst_locked", 0, 1, 0);
    expect_val("rst_err",    1, 0, 0);
    expect_val("rst_err",    1, 1, 0);
    expect_val("rst_words",  2, 0, 0);
    expect_val("rst_txdata", 8, 0, 64'hBC95);
    expect_val("rst_txk",    9, 0, 64'h2);
    rst_a = 1'b0;

    wait_lock("lock_time", 0, 0, 68);
    wait_lock("lock_time", 0, 1, 68);

    repeat (10000) @(negedge clk);
    expect_val("long_err",    1, 0, 0);
    expect_val("long_err",    1, 1, 0);
    expect_val("long_locked", 0, 0, 1);
    expect_val("long_locked", 0, 1, 1);
    n_cmp++;
    if (if_a.locked_o !== 2'b11) begin
      n_bad++;
      $display("FAIL long_locked_all: got 0x%0h, expected 0x3", if_a.locked_o);
    end
    n_cmp++;
    if (if_a.err_cnt_o !== 64'd0) begin
      n_bad++;
      $display("FAIL long_err_all: got 0x%0h, expected 0x0", if_a.err_cnt_o);
    end

    wait_safe_a();
    if_a.inj_err_i = 2'b01;
    @(negedge clk);
    if_a.inj_err_i = 2'b00;
    repeat (6) @(negedge clk);
    expect_val("inj_err",    1, 0, 1);
    expect_val("inj_other",  1, 1, 0);
    expect_val("inj_locked", 0, 0, 1);

    disperr_a = 4'b0001;
    repeat (4) @(negedge clk);
    disperr_a = 4'b0000;
    repeat (2) @(negedge clk);
    expect_val("disp_unlock", 0, 0, 0);
    expect_val("disp_err",    1, 0, 5);
    expect_val("disp_other",  1, 1, 0);
    wait_lock("disp_relock", 0, 0, 70);

    // Clear lands on the same edge the corrupted word is checked.
    wait_safe_a();
    if_a.inj_err_i = 2'b01;
    @(negedge clk);
    if_a.inj_err_i = 2'b00;
    @(negedge clk);
    if_a.cnt_clr_i = 1'b1;
    @(negedge clk);
    if_a.cnt_clr_i = 1'b0;
    expect_val("clr_err",   1, 0, 0);
    expect_val("clr_words", 2, 0, 0);
    wait_safe_a();
    if_a.inj_err_i = 2'b01;
    @(negedge clk);
    if_a.inj_err_i = 2'b00;
    repeat (6) @(negedge clk);
    expect_val("clr_next_err", 1, 0, 1);

    rst_b = 1'b0;
    wait_lock("b_lock", 3, 0, 20);
    for (int i = 0; i < 60; i++) begin
      if_b.inj_err_i = (i % 3 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    if_b.inj_err_i = 1'b0;
    repeat (4) @(negedge clk);
    expect_val("sat_err",    4, 0, 64'hF);
    expect_val("sat_words",  5, 0, 64'hF);
    expect_val("sat_locked", 3, 0, 1);

    rst_b = 1'b1;
    @(negedge clk);
    expect_val("midrst_locked", 3, 0, 0);
    expect_val("midrst_err",    4, 0, 0);
    expect_val("midrst_words",  5, 0, 0);
    expect_val("midrst_txdata", 6, 0, 64'hBC959595);
    expect_val("midrst_txk",    7, 0, 64'h8);
    n_cmp++;
    if (if_b.locked_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_locked_direct: got 0x%0h, expected 0x0", if_b.locked_o);
    end
    n_cmp++;
    if (if_b.err_cnt_o !== 4'h0) begin
      n_bad++;
      $display("FAIL midrst_err_direct: got 0x%0h, expected 0x0", if_b.err_cnt_o);
    end
    @(negedge clk);
    rst_b = 1'b0;
    wait_lock("midrst_relock", 3, 0, 20);

    repeat (2) @(negedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d expectations never compared", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
